instr_encoder_loader: RTL and testbench

- Instruction encoder and loader: the producer side of the control Decoder's opcode map.
- Accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit MIPS word using the opcodes the Decoder recognises.
- Writes words sequentially into instruction memory, then flags completion.
- Used to boot test programs into the pipelined CPU without a pre-baked memory image.

---
 rtl/instr_encoder_loader_pkg.sv | 26 ++
 rtl/instr_encoder_loader_packer.sv | 30 +++
 rtl/instr_encoder_loader.sv | 123 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode map, op_sel codes and loader state encoding.
// The Decoder imports the same opcode constants, so the two cannot drift apart.
package instr_encoder_loader_pkg;

  // lw/sw and beq/bne are swapped relative to textbook MIPS
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b101011;
  localparam logic [5:0] OP_SW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_BNE   = 6'b000100;

  localparam logic [2:0] SEL_RTYPE = 3'd0;
  localparam logic [2:0] SEL_ADDI  = 3'd1;
  localparam logic [2:0] SEL_LW    = 3'd2;
  localparam logic [2:0] SEL_SW    = 3'd3;
  localparam logic [2:0] SEL_BEQ   = 3'd4;
  localparam logic [2:0] SEL_BNE   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: op_sel plus instruction fields -> 32-bit word.
// Codes 6 and 7 have no encoding; they yield a zero word and raise illegal.
module instr_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_sel)
      SEL_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      SEL_ADDI:  word = {OP_ADDI, rs, rt, imm};
      SEL_LW:    word = {OP_LW, rs, rt, imm};
      SEL_SW:    word = {OP_SW, rs, rt, imm};
      SEL_BEQ:   word = {OP_BEQ, rs, rt, imm};
      SEL_BNE:   word = {OP_BNE, rs, rt, imm};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs field-level requests into words and streams
// them into instruction memory through a single pending-write register.
//
// state | meaning
// IDLE  | waiting for start_i, no requests taken
// LOAD  | accepting requests, writing words sequentially
// DONE  | session complete, done_o high until the next start_i
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        finish_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_sel_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic        imem_busy_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic [5:0]  count_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  state_t      state, state_nx;
  logic        pend, fin, err;
  logic [31:0] ptr, data_q;
  logic [5:0]  count, count_nx;
  logic        accept, commit, pend_nx, room;
  logic [31:0] word;
  logic        illegal;

  instr_packer u_packer (
    .op_sel  (op_sel_i),
    .rs      (rs_i),
    .rt      (rt_i),
    .rd      (rd_i),
    .funct   (funct_i),
    .imm     (imm_i),
    .word    (word),
    .illegal (illegal)
  );

  // Reserved slots include the word still waiting in the output register.
  assign room     = ({1'b0, count} + {6'b000000, pend}) < DEPTH_W;
  assign commit   = pend && !imem_busy_i;
  assign accept   = req_valid_i && req_ready_o;
  assign pend_nx  = (pend && !commit) || (accept && !illegal);
  assign count_nx = count + 6'(commit);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_i) state_nx = ST_LOAD;
      ST_LOAD: begin
        if ((fin || finish_i || ({1'b0, count_nx} == DEPTH_W)) && !pend_nx)
          state_nx = ST_DONE;
      end
      ST_DONE: if (start_i) state_nx = ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    case (state)
      ST_LOAD: req_ready_o = !fin && (!pend || !imem_busy_i) && room;
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend   <= 1'b0;
      fin    <= 1'b0;
      err    <= 1'b0;
      ptr    <= BASE_ADDR;
      data_q <= '0;
      count  <= '0;
    end else if ((state != ST_LOAD) && start_i) begin
      pend  <= 1'b0;
      fin   <= 1'b0;
      err   <= 1'b0;
      ptr   <= BASE_ADDR;
      count <= '0;
    end else if (state == ST_LOAD) begin
      pend <= pend_nx;
      if (commit) begin
        ptr   <= ptr + 32'd4;
        count <= count_nx;
      end
      if (accept && !illegal) data_q <= word;
      if (accept && illegal)  err    <= 1'b1;
      if (finish_i)           fin    <= 1'b1;
    end
  end

  assign imem_we_o   = pend;
  assign imem_addr_o = ptr;
  assign imem_data_o = data_q;
  assign count_o     = count;
  assign err_o       = err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a DEPTH=32 instance for the main
// scenarios and a DEPTH=4 instance, on shared inputs, for the capacity limit.
module tb_instr_encoder_loader;

  logic        clk, rst, start, finish, valid, busy;
  logic [2:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        ready, we, done, err;
  logic [31:0] addr, data;
  logic [5:0]  count;
  logic        ready4, we4, done4, err4;
  logic [31:0] addr4, data4;
  logic [5:0]  count4;

  int checks;
  int failures;

  instr_encoder_loader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .req_valid_i(valid), .req_ready_o(ready), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
    .imem_busy_i(busy), .imem_we_o(we), .imem_addr_o(addr), .imem_data_o(data),
    .count_o(count), .done_o(done), .err_o(err)
  );

  instr_encoder_loader #(.DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .req_valid_i(valid), .req_ready_o(ready4), .op_sel_i(op_sel),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
    .imem_busy_i(busy), .imem_we_o(we4), .imem_addr_o(addr4), .imem_data_o(data4),
    .count_o(count4), .done_o(done4), .err_o(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input logic [2:0] s, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] i);
    op_sel = s; rs = a; rt = b; rd = d; funct = f; imm = i; valid = 1'b1;
  endtask

  // Ends at a negedge with the DUTs in LOAD and a fresh session.
  task automatic fresh_session();
    @(negedge clk); rst = 1'b1; valid = 1'b0; start = 1'b0; finish = 1'b0; busy = 1'b0;
    @(negedge clk); rst = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; finish = 1'b0; busy = 1'b0;
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags done=%b err=%b exp=0,0", done, err); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", ready); end
    @(negedge clk); valid = 1'b0;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL idle_no_write got=%b exp=0", we); end
  endtask

  task automatic test_rtype();
    fresh_session();
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'hAAAA);
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rtype_ready got=%b exp=1", ready); end
    @(negedge clk); valid = 1'b0;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL rtype_we got=%b exp=1", we); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL rtype_addr got=%h exp=00000000", addr); end
    checks++; if (data !== 32'h00221820) begin failures++; $display("FAIL rtype_data got=%h exp=00221820", data); end
    @(negedge clk);
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL rtype_count got=%0d exp=1", count); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rtype_we_after got=%b exp=0", we); end
  endtask

  task automatic test_back_to_back();
    fresh_session();
    set_req(3'd1, 5'd0, 5'd8, 5'd31, 6'h3F, 16'hFFFF);
    @(negedge clk);
    set_req(3'd2, 5'd8, 5'd9, 5'd0, 6'h0, 16'd4);
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    checks++; if (we !== 1'b1 || addr !== 32'h0 || data !== 32'h2008FFFF)
      begin failures++; $display("FAIL b2b_word0 we=%b addr=%h data=%h exp 1 00000000 2008ffff", we, addr, data); end
    @(negedge clk); valid = 1'b0;
    checks++; if (we !== 1'b1 || addr !== 32'h4 || data !== 32'hAD090004)
      begin failures++; $display("FAIL b2b_word1 we=%b addr=%h data=%h exp 1 00000004 ad090004", we, addr, data); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL b2b_count_mid got=%0d exp=1", count); end
    @(negedge clk);
    checks++; if (count !== 6'd2 || we !== 1'b0) begin failures++; $display("FAIL b2b_count got=%0d we=%b exp=2 0", count, we); end
  endtask

  task automatic test_busy();
    fresh_session();
    set_req(3'd3, 5'd29, 5'd31, 5'd0, 6'h0, 16'd8);
    @(negedge clk); valid = 1'b0; busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (we !== 1'b1 || addr !== 32'h0 || data !== 32'h8FBF0008)
        begin failures++; $display("FAIL busy_hold cyc=%0d we=%b addr=%h data=%h exp 1 00000000 8fbf0008", i, we, addr, data); end
      checks++; if (ready !== 1'b0 || count !== 6'd0)
        begin failures++; $display("FAIL busy_stall cyc=%0d ready=%b count=%0d exp 0 0", i, ready, count); end
      @(negedge clk);
    end
    busy = 1'b0;
    #1;
    checks++; if (we !== 1'b1 || data !== 32'h8FBF0008) begin failures++; $display("FAIL busy_release we=%b data=%h exp 1 8fbf0008", we, data); end
    @(negedge clk);
    checks++; if (count !== 6'd1 || we !== 1'b0 || addr !== 32'h4)
      begin failures++; $display("FAIL busy_commit count=%0d we=%b addr=%h exp 1 0 00000004", count, we, addr); end
  endtask

  task automatic test_illegal();
    fresh_session();
    set_req(3'd7, 5'd5, 5'd6, 5'd7, 6'h1, 16'h1234);
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL illegal_ready got=%b exp=1", ready); end
    @(negedge clk);
    set_req(3'd4, 5'd1, 5'd1, 5'd0, 6'h0, 16'hFFFF);
    checks++; if (we !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL illegal_nowrite we=%b err=%b exp 0 1", we, err); end
    @(negedge clk); valid = 1'b0;
    checks++; if (we !== 1'b1 || addr !== 32'h0 || data !== 32'h1421FFFF)
      begin failures++; $display("FAIL beq_word we=%b addr=%h data=%h exp 1 00000000 1421ffff", we, addr, data); end
    @(negedge clk); finish = 1'b1;
    checks++; if (count !== 6'd1 || err !== 1'b1) begin failures++; $display("FAIL illegal_count count=%0d err=%b exp 1 1", count, err); end
    @(negedge clk); finish = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL finish_idle_done got=%b exp=1", done); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b0 || err !== 1'b0 || count !== 6'd0)
      begin failures++; $display("FAIL restart done=%b err=%b count=%0d exp 0 0 0", done, err, count); end
  endtask

  task automatic test_depth();
    fresh_session();
    for (int i = 0; i < 5; i++) begin
      set_req(3'd1, 5'd0, 5'(i), 5'd0, 6'h0, 16'(i));
      #1;
      checks++; if (ready4 !== (i < 4)) begin failures++; $display("FAIL depth_ready req=%0d got=%b exp=%b", i, ready4, (i < 4)); end
      if (i > 0) begin
        checks++; if (we4 !== 1'b1 || addr4 !== 32'((i - 1) * 4))
          begin failures++; $display("FAIL depth_write req=%0d we=%b addr=%h exp 1 %h", i, we4, addr4, 32'((i - 1) * 4)); end
      end
      @(negedge clk);
    end
    checks++; if (done4 !== 1'b1 || count4 !== 6'd4) begin failures++; $display("FAIL depth_done done=%b count=%0d exp 1 4", done4, count4); end
    @(negedge clk);
    checks++; if (we4 !== 1'b0 || count4 !== 6'd4 || ready4 !== 1'b0)
      begin failures++; $display("FAIL depth_fifth we=%b count=%0d ready=%b exp 0 4 0", we4, count4, ready4); end
    valid = 1'b0;
  endtask

  task automatic test_finish_and_reset();
    fresh_session();
    set_req(3'd5, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0010);
    finish = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fin_ready got=%b exp=1", ready); end
    @(negedge clk); valid = 1'b0; finish = 1'b0;
    checks++; if (we !== 1'b1 || data !== 32'h10430010 || done !== 1'b0)
      begin failures++; $display("FAIL fin_write we=%b data=%h done=%b exp 1 10430010 0", we, data, done); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fin_closed got=%b exp=0", ready); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || count !== 6'd1 || we !== 1'b0)
      begin failures++; $display("FAIL fin_done done=%b count=%0d we=%b exp 1 1 0", done, count, we); end
    fresh_session();
    set_req(3'd2, 5'd4, 5'd5, 5'd0, 6'h0, 16'h0020);
    @(negedge clk); valid = 1'b0; busy = 1'b1;
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL rst_pending got=%b exp=1", we); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (we !== 1'b0 || addr !== 32'h0 || data !== 32'h0 || count !== 6'd0 || done !== 1'b0 || err !== 1'b0 || ready !== 1'b0)
      begin failures++; $display("FAIL rst_mid we=%b addr=%h data=%h count=%0d done=%b err=%b ready=%b exp all 0", we, addr, data, count, done, err, ready); end
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (we !== 1'b0 || count !== 6'd0) begin failures++; $display("FAIL rst_dropped we=%b count=%0d exp 0 0", we, count); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; finish = 1'b0; valid = 1'b0; busy = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;
    test_reset();
    test_rtype();
    test_back_to_back();
    test_busy();
    test_illegal();
    test_depth();
    test_finish_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
